// File: rtl/exec_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_wb_stage_pkg
//  Description : Shared definitions for the execute/writeback stage: opcode
//                encodings, multiplier FSM state encoding and the index of
//                the register mirrored as the stack pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_wb_stage_pkg;

    typedef logic [2:0] opcode_t;

    localparam opcode_t OP_ADD  = 3'd0;
    localparam opcode_t OP_SUB  = 3'd1;
    localparam opcode_t OP_AND  = 3'd2;
    localparam opcode_t OP_OR   = 3'd3;
    localparam opcode_t OP_XOR  = 3'd4;
    localparam opcode_t OP_MOVI = 3'd5;
    localparam opcode_t OP_MUL  = 3'd6;
    localparam opcode_t OP_NOP  = 3'd7;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MUL_RUN = 1'b1;

    // Register whose writes must be followed by an sp refresh strobe
    localparam int SP_IDX = 3;

endpackage
`default_nettype wire

// File: rtl/exec_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : exec_wb_stage_if
//  Description : Issue handshake, operand/immediate inputs, register-file
//                write port, sp strobe, flags and busy status of the
//                execute/writeback stage.
//                master : issuer side (drives in_valid/opcode/operands/flush)
//                slave  : stage side  (drives in_ready/wb_*/sp_en/flags/busy)
//  Revision    : 1.0 - initial release
// ============================================================================
interface exec_wb_stage_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] imm;
    logic              flush;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sp_en;
    logic              flag_z;
    logic              flag_c;
    logic              busy;

    modport master (
        output in_valid, opcode, ra_addr, rb_addr, dst_addr,
               ra_data, rb_data, imm, flush,
        input  in_ready, wb_en, wb_addr, wr_data, sp_en, flag_z, flag_c, busy
    );

    modport slave (
        input  in_valid, opcode, ra_addr, rb_addr, dst_addr,
               ra_data, rb_data, imm, flush,
        output in_ready, wb_en, wb_addr, wr_data, sp_en, flag_z, flag_c, busy
    );
endinterface
`default_nettype wire

// File: rtl/exec_wb_stage_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : exec_mul_seq
//  Description : Iterative shift-add multiplier retiring BPC bits of the
//                multiplier operand per cycle.
//                clk, rst_n   : clock, async active-low reset
//                i_start      : load operands (first partial product folded in)
//                i_step       : perform one further iteration
//                i_a, i_b     : multiplicand / multiplier
//                o_done       : final iteration is being performed this cycle
//                o_product    : full-width product, valid while o_done=1
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_mul_seq #(
    parameter int DATA_W     = 8,
    parameter int MUL_CYCLES = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_start,
    input  wire logic                i_step,
    input  wire logic [DATA_W-1:0]   i_a,
    input  wire logic [DATA_W-1:0]   i_b,
    output logic                     o_done,
    output logic [2*DATA_W-1:0]      o_product
);
    localparam int BPC   = DATA_W / MUL_CYCLES;
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(MUL_CYCLES - 1);

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_a;
    logic [DATA_W-1:0]   r_b;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_pp_start;
    logic [2*DATA_W-1:0] w_pp_step;

    function automatic logic [2*DATA_W-1:0] partial(
        input logic [2*DATA_W-1:0] a,
        input logic [BPC-1:0]      bits
    );
        logic [2*DATA_W-1:0] s;
        s = '0;
        for (int j = 0; j < BPC; j++) begin
            if (bits[j]) s = s + (a << j);
        end
        return s;
    endfunction

    assign w_a_ext    = {{DATA_W{1'b0}}, i_a};
    assign w_pp_start = partial(w_a_ext, i_b[BPC-1:0]);
    assign w_pp_step  = partial(r_a, r_b[BPC-1:0]);

    // The lowest chunk is retired on the start edge so the last chunk is
    // retired MUL_CYCLES-1 cycles later, letting the result be written back
    // exactly MUL_CYCLES cycles after the operation was accepted.
    assign o_done    = i_step && (r_cnt == c_last);
    assign o_product = r_acc + w_pp_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_acc <= w_pp_start;
            r_a   <= w_a_ext << BPC;
            r_b   <= i_b >> BPC;
            r_cnt <= CNT_W'(1);
        end else if (i_step) begin
            r_acc <= r_acc + w_pp_step;
            r_a   <= r_a << BPC;
            r_b   <= r_b >> BPC;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/exec_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : exec_wb_stage
//  Description : Execute/writeback stage behind a 4-entry register file.
//                Single-cycle ALU ops, iterative MUL, write-back forwarding,
//                Z/C flags, sp refresh strobe and synchronous flush.
//                clk, rst_n : clock, async active-low reset
//                bus        : exec_wb_stage_if.slave (issue handshake,
//                             operands, write port, sp_en, flags, busy)
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_wb_stage #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 2,
    parameter int MUL_CYCLES = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    exec_wb_stage_if.slave bus
);
    import exec_wb_stage_pkg::*;

    localparam logic [ADDR_W-1:0] c_sp_addr = ADDR_W'(SP_IDX);

    logic [0:0]          r_state;
    logic [0:0]          w_state_next;
    logic                w_busy;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_mul_start;
    logic                w_mul_done;
    logic [2*DATA_W-1:0] w_mul_prod;
    logic [DATA_W-1:0]   w_op_a;
    logic [DATA_W-1:0]   w_op_b;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_alu_c;
    logic                w_alu_wr;
    logic [ADDR_W-1:0]   r_mul_dst;
    logic                r_wb_en;
    logic [ADDR_W-1:0]   r_wb_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_sp_en;
    logic                r_flag_z;
    logic                r_flag_c;

    // A flushed cycle never accepts, even while the stage is idle
    assign w_accept    = bus.in_valid && w_in_ready && !bus.flush;
    assign w_mul_start = w_accept && (bus.opcode == OP_MUL);

    // Bypass the value being written this cycle; the file still shows the old one
    assign w_op_a = (r_wb_en && (bus.ra_addr == r_wb_addr)) ? r_wr_data : bus.ra_data;
    assign w_op_b = (r_wb_en && (bus.rb_addr == r_wb_addr)) ? r_wr_data : bus.rb_data;

    // ---------------- multiplier FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_mul_start) w_state_next = ST_MUL_RUN;
            ST_MUL_RUN: if (bus.flush || w_mul_done) w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state == ST_MUL_RUN);
        w_in_ready = (r_state == ST_IDLE);
    end

    exec_mul_seq #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_step    (w_busy),
        .i_a       (w_op_a),
        .i_b       (w_op_b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_mul_dst <= '0;
        else if (w_mul_start) r_mul_dst <= bus.dst_addr;
    end

    // ---------------- single-cycle ALU ----------------
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = r_flag_c;
        w_alu_wr  = 1'b1;
        case (bus.opcode)
            OP_ADD:  {w_alu_c, w_alu_res} = {1'b0, w_op_a} + {1'b0, w_op_b};
            OP_SUB:  begin
                w_alu_res = w_op_a - w_op_b;
                w_alu_c   = (w_op_a < w_op_b);
            end
            OP_AND:  begin w_alu_res = w_op_a & w_op_b; w_alu_c = 1'b0; end
            OP_OR:   begin w_alu_res = w_op_a | w_op_b; w_alu_c = 1'b0; end
            OP_XOR:  begin w_alu_res = w_op_a ^ w_op_b; w_alu_c = 1'b0; end
            OP_MOVI: w_alu_res = bus.imm;
            default: w_alu_wr = 1'b0; // MUL completes later, NOP never writes
        endcase
    end

    // ---------------- write-back register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_en   <= 1'b0;
            r_wb_addr <= '0;
            r_wr_data <= '0;
            r_sp_en   <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
        end else begin
            r_wb_en <= 1'b0;
            r_sp_en <= r_wb_en && (r_wb_addr == c_sp_addr);
            if (!bus.flush) begin
                if (w_mul_done) begin
                    r_wb_en   <= 1'b1;
                    r_wb_addr <= r_mul_dst;
                    r_wr_data <= w_mul_prod[DATA_W-1:0];
                    r_flag_z  <= (w_mul_prod[DATA_W-1:0] == '0);
                    r_flag_c  <= |w_mul_prod[2*DATA_W-1:DATA_W];
                end else if (w_accept && w_alu_wr) begin
                    r_wb_en   <= 1'b1;
                    r_wb_addr <= bus.dst_addr;
                    r_wr_data <= w_alu_res;
                    r_flag_z  <= (w_alu_res == '0);
                    r_flag_c  <= w_alu_c;
                end
            end
        end
    end

    assign bus.in_ready = w_in_ready;
    assign bus.busy     = w_busy;
    assign bus.wb_en    = r_wb_en;
    assign bus.wb_addr  = r_wb_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.sp_en    = r_sp_en;
    assign bus.flag_z   = r_flag_z;
    assign bus.flag_c   = r_flag_c;
endmodule
`default_nettype wire

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Execute/writeback stage directly downstream of the 4-entry register file.
- Consumes the file's two read operands, performs one ALU or multiply operation, and drives the file's write port (wb_en, wb_addr, wr_data).
- Drives sp_en so the file refreshes its sp copy after a write to R3.
- Provides a valid/ready accept handshake, a multi-cycle multiplier FSM, write-back forwarding, Z/C flags and a synchronous flush.

Parameters:
- DATA_W, 8, operand/result width.
- ADDR_W, 2, register address width.
- MUL_CYCLES, 4, multiply iterations. DATA_W must be divisible by MUL_CYCLES. Bits retired per cycle: BPC = DATA_W/MUL_CYCLES.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  stage can accept.
- opcode  in  3  operation code (see Behaviour).
- ra_addr  in  ADDR_W  source A index (same value presented to the file's ra).
- rb_addr  in  ADDR_W  source B index.
- dst_addr  in  ADDR_W  destination index.
- ra_data  in  DATA_W  file ra_out.
- rb_data  in  DATA_W  file rb_out.
- imm  in  DATA_W  immediate for MOVI.
- flush  in  1  synchronous kill of in-flight work.
- wb_en  out  1  write strobe to file.
- wb_addr  out  ADDR_W  write index.
- wr_data  out  DATA_W  write data.
- sp_en  out  1  sp refresh strobe.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- busy  out  1  multiply in progress.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except in_ready=1. FSM=IDLE, counter=0, partial products cleared. Outputs update on the first clk edge after release.
- Accept: in_valid && in_ready at a rising edge.
- Opcodes:
  - 0 ADD: {C,res}=A+B.
  - 1 SUB: res=A-B, C=(A<B) borrow.
  - 2 AND, 3 OR, 4 XOR: C cleared.
  - 5 MOVI: res=imm, C unchanged.
  - 6 MUL: res=low DATA_W bits of A*B, C=1 if high half is non-zero.
  - 7 NOP: no write, flags unchanged.
- Flags update only on writing ops: Z=(res==0).
- Single-cycle ops: accepted at edge N → wb_en=1 with wb_addr/wr_data/flags valid in cycle N+1, one cycle only. in_ready stays 1, so back-to-back issue sustains one write per cycle.
- Forwarding: if wb_en=1 this cycle and ra_addr==wb_addr, use wr_data as A instead of ra_data. Same for B/rb_addr. Both may forward simultaneously.
- MUL FSM:
  - IDLE: accept MUL → MUL_RUN. Latch the forwarded A/B and dst; counter=0; busy=1; in_ready=0.
  - MUL_RUN: each cycle add the partial product for BPC bits of B (shift-add), counter++. At counter==MUL_CYCLES-1 → IDLE.
  - Exit: wb_en=1 with the result in the cycle after the last iteration. MUL accepted at N → wb_en at N+MUL_CYCLES (N+4 default).
  - busy falls and in_ready rises together with that wb_en. A new op may be accepted in the same cycle and still forwards from the MUL result.
- sp_en: 1 in the cycle after any wb_en cycle whose wb_addr==3; otherwise 0.
- flush=1 at an edge:
  - Suppresses any wb_en for the next cycle.
  - Aborts MUL_RUN → IDLE with no writeback; busy=0, in_ready=1.
  - Discards an op offered in the same cycle (not accepted).
  - Flags unchanged.
- rst_n asserted mid-MUL: immediate IDLE, no writeback after release.
- Arithmetic is unsigned modulo 2^DATA_W; wrap-around is legal.

Decomposition:
- Shared package: opcode localparams (OP_ADD..OP_NOP), FSM state encoding (ST_IDLE, ST_MUL_RUN), and the R3 index constant SP_IDX=3.
- One sub-module, exec_mul_seq: iterative shift-add multiplier with start/done handshake, holding the counter and partial-product register.
- ALU and forwarding muxes stay inline.

Test Plan:
- Reset, then ADD with ra_data=0xF0, rb_data=0x20, dst=1 → next cycle wb_en=1, wb_addr=1, wr_data=0x10, C=1, Z=0.
- SUB R2=R0-R0 (0x05-0x05), dst=2 → wr_data=0x00, Z=1, C=0. Then SUB 0x03-0x04 → wr_data=0xFF, C=1.
- Back-to-back: MOVI imm=0x07→R3, then ADD R3+R3 with stale ra_data=rb_data=0x00 → forwarded result 0x0E. sp_en=1 in the cycle after the MOVI write.
- MUL 0x0C*0x15 accepted at cycle N → in_ready=0 and busy=1 for cycles N+1..N+3; wb_en at N+4 with wr_data=0xFC, C=0. Then 0x20*0x10 → wr_data=0x00, Z=1, C=1.
- MUL accepted, flush at N+2 → no wb_en through N+6; in_ready=1 at N+3.
- rst_n low mid-MUL → all outputs 0 and in_ready=1 immediately; no wb_en after release.
